// File: rtl/gpio_cond_pkg.sv
// gpio_cond_pkg: shared defaults and debounce state type for the GPIO input conditioner.
package gpio_cond_pkg;
    localparam int WIDTH_D       = 8;
    localparam int SYNC_STAGES_D = 2;
    localparam int DEBOUNCE_W_D  = 8;
    typedef enum logic {DB_IDLE, DB_COUNT} db_state_e;
endpackage

// File: rtl/gpio_debounce_bit.sv
// gpio_debounce_bit: per-bit synchroniser, debounce counter, stable value and edge pulses.
module gpio_debounce_bit
    import gpio_cond_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_D,
    parameter int DEBOUNCE_W  = DEBOUNCE_W_D
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pad,
    input  logic [DEBOUNCE_W-1:0] limit,
    output logic                  stable,
    output logic                  edge_rise,
    output logic                  edge_fall
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DEBOUNCE_W-1:0]  cnt, cnt_nxt;
    logic                   sync_out, commit, stable_nxt;
    db_state_e              state;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // The state is implied by disagreement between the synchronised input and the stable value.
    always_comb begin
        state      = (sync_out == stable) ? DB_IDLE : DB_COUNT;
        commit     = (state == DB_COUNT) && (cnt >= limit);
        cnt_nxt    = (state == DB_IDLE || commit) ? '0 : cnt + 1'b1;
        stable_nxt = commit ? sync_out : stable;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q    <= '0;
            cnt       <= '0;
            stable    <= 1'b0;
            edge_rise <= 1'b0;
            edge_fall <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], pad};
            cnt       <= cnt_nxt;
            stable    <= stable_nxt;
            edge_rise <= commit & sync_out;
            edge_fall <= commit & ~sync_out;
        end
    end
endmodule

// File: rtl/gpio_input_conditioner.sv
// gpio_input_conditioner: conditions raw pad inputs into debounced values, edge pulses
// and latched interrupt pending flags.
module gpio_input_conditioner
    import gpio_cond_pkg::*;
#(
    parameter int WIDTH       = WIDTH_D,
    parameter int SYNC_STAGES = SYNC_STAGES_D,
    parameter int DEBOUNCE_W  = DEBOUNCE_W_D
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      pad_p2c,
    input  logic [DEBOUNCE_W-1:0] debounce_limit,
    input  logic [WIDTH-1:0]      rise_en,
    input  logic [WIDTH-1:0]      fall_en,
    input  logic [WIDTH-1:0]      irq_clear,
    output logic [WIDTH-1:0]      gpio_read,
    output logic [WIDTH-1:0]      edge_rise,
    output logic [WIDTH-1:0]      edge_fall,
    output logic [WIDTH-1:0]      irq_pending,
    output logic                  irq
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gpio_debounce_bit #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEBOUNCE_W (DEBOUNCE_W)
        ) u_db (
            .clk      (clk),
            .reset    (reset),
            .pad      (pad_p2c[i]),
            .limit    (debounce_limit),
            .stable   (gpio_read[i]),
            .edge_rise(edge_rise[i]),
            .edge_fall(edge_fall[i])
        );
    end

    // A new enabled edge wins over a coincident clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            irq_pending <= '0;
        else
            irq_pending <= (edge_rise & rise_en) | (edge_fall & fall_en) | (irq_pending & ~irq_clear);
    end

    assign irq = |irq_pending;
endmodule

// File: tb/tb_gpio_input_conditioner.sv
// tb_gpio_input_conditioner: directed and randomized checks against a run-length reference model.
module tb_gpio_input_conditioner;
    logic       clk = 0;
    logic       reset;
    logic [7:0] pad_p2c, debounce_limit, rise_en, fall_en, irq_clear;
    logic [7:0] gpio_read, edge_rise, edge_fall, irq_pending;
    logic       irq;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] hist[$];
    logic [7:0] m_stable, m_rise, m_fall, m_pend;
    int         run[8];

    gpio_input_conditioner dut (
        .clk(clk), .reset(reset), .pad_p2c(pad_p2c), .debounce_limit(debounce_limit),
        .rise_en(rise_en), .fall_en(fall_en), .irq_clear(irq_clear),
        .gpio_read(gpio_read), .edge_rise(edge_rise), .edge_fall(edge_fall),
        .irq_pending(irq_pending), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist = {};
        for (int k = 0; k < 2; k++) hist.push_back(8'h00);
        m_stable = 0; m_rise = 0; m_fall = 0; m_pend = 0;
        for (int k = 0; k < 8; k++) run[k] = 0;
    endtask

    // A pad value is seen two samples late; a change commits once it has been seen on limit+1 consecutive samples.
    task automatic model_step();
        logic [7:0] s;
        s = hist.pop_front();
        hist.push_back(pad_p2c);
        m_pend = (m_rise & rise_en) | (m_fall & fall_en) | (m_pend & ~irq_clear);
        m_rise = 0;
        m_fall = 0;
        for (int k = 0; k < 8; k++) begin
            if (s[k] != m_stable[k]) begin
                run[k]++;
                if (run[k] > int'(debounce_limit)) begin
                    m_stable[k] = s[k];
                    if (s[k]) m_rise[k] = 1'b1; else m_fall[k] = 1'b1;
                    run[k] = 0;
                end
            end else run[k] = 0;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".gpio_read"}, gpio_read, m_stable);
        chk({tag, ".edge_rise"}, edge_rise, m_rise);
        chk({tag, ".edge_fall"}, edge_fall, m_fall);
        chk({tag, ".irq_pending"}, irq_pending, m_pend);
        chk({tag, ".irq"}, {7'd0, irq}, {7'd0, |m_pend});
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (reset) model_step();
        #1;
        check_model(tag);
    endtask

    task automatic reset_pulse();
        reset = 0;
        model_reset();
        #2;
        reset = 1;
    endtask

    initial begin
        reset = 0; pad_p2c = 8'hFF; debounce_limit = 8'd4;
        rise_en = 0; fall_en = 0; irq_clear = 0;
        model_reset();
        #1;
        chk("reset.gpio_read", gpio_read, 8'h00);
        repeat (3) tick("reset_hold");
        chk("reset.edge_rise", edge_rise, 8'h00);
        pad_p2c = 8'h00;
        reset = 1;
        repeat (5) tick("reset_release");
        chk("release.no_edge", edge_rise | edge_fall, 8'h00);

        pad_p2c = 8'h01;
        repeat (6) tick("step");
        chk("step.not_yet", gpio_read, 8'h00);
        tick("step");
        chk("step.latency7", gpio_read, 8'h01);
        chk("step.rise_pulse", edge_rise, 8'h01);
        chk("step.no_fall", edge_fall, 8'h00);
        tick("step");
        chk("step.pulse_end", edge_rise, 8'h00);

        pad_p2c = 8'h09;
        repeat (3) tick("glitch");
        pad_p2c = 8'h01;
        repeat (10) begin
            tick("glitch");
            chk("glitch.read", gpio_read, 8'h01);
            chk("glitch.edges", edge_rise | edge_fall, 8'h00);
        end

        reset_pulse();
        debounce_limit = 8'd0;
        pad_p2c = 8'hA5;
        repeat (2) tick("bypass");
        chk("bypass.early", gpio_read, 8'h00);
        tick("bypass");
        chk("bypass.read", gpio_read, 8'hA5);
        chk("bypass.rise", edge_rise, 8'hA5);

        reset_pulse();
        rise_en = 8'h01;
        pad_p2c = 8'h01;
        repeat (4) tick("irq");
        chk("irq.pending", irq_pending, 8'h01);
        chk("irq.irq", {7'd0, irq}, 8'h01);
        pad_p2c = 8'h00;
        repeat (3) tick("irq");
        pad_p2c = 8'h01;
        repeat (3) tick("irq");
        chk("irq.second_rise", edge_rise, 8'h01);
        irq_clear = 8'h01;
        tick("irq");
        chk("irq.set_wins", irq_pending, 8'h01);
        irq_clear = 8'h00;
        tick("irq");
        irq_clear = 8'h01;
        tick("irq");
        chk("irq.cleared", irq_pending, 8'h00);
        chk("irq.irq_low", {7'd0, irq}, 8'h00);
        irq_clear = 8'h00;

        reset_pulse();
        rise_en = 8'h00;
        debounce_limit = 8'd10;
        pad_p2c = 8'h04;
        repeat (7) tick("midcnt");
        reset = 0;
        model_reset();
        #1;
        chk("midcnt.async_read", gpio_read, 8'h00);
        chk("midcnt.async_pend", irq_pending, 8'h00);
        tick("midcnt_hold");
        reset = 1;
        repeat (12) tick("midcnt_after");
        chk("midcnt.no_rise_yet", edge_rise, 8'h00);
        tick("midcnt_after");
        chk("midcnt.rise13", edge_rise, 8'h04);

        for (int n = 0; n < 600; n++) begin
            if (n % 64 == 0) debounce_limit = 8'($urandom_range(0, 3));
            if (n % 32 == 0) begin
                rise_en = 8'($urandom);
                fall_en = 8'($urandom);
            end
            pad_p2c = pad_p2c ^ 8'($urandom & $urandom);
            irq_clear = 8'($urandom & $urandom & $urandom);
            tick("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
